// File: rtl/datapath_p_pkg.sv
// datapath_p_pkg: control-select enums and multiplier states shared by the datapath.
package datapath_p_pkg;
    localparam int IR_W = 16;
    typedef enum logic [3:0] {AluAdd, AluAdc, AluSub, AluSbc, AluAnd, AluOr, AluXor, AluPassA, AluPassB} alu_functions_t;
    typedef enum logic [2:0] {PcLr, PcAlu, PcSys, Pc1, PcInt} pc_select_t;
    typedef enum logic [1:0] {Op1Rd1, Op1Pc, Op1Sp} op1_select_t;
    typedef enum logic {Op2Rd2, Op2Imm} op2_select_t;
    typedef enum logic {ImmShort, ImmLong} imm_select_t;
    typedef enum logic {WdSys, WdAlu} wd_select_t;
    typedef enum logic [1:0] {Rs1Rd, Rs1Ra, Rs1Seven} rs1_select_t;
    typedef enum logic [1:0] {RwRd, RwRa, RwSeven} rw_select_t;
    typedef enum logic {LrPc1, LrSys} lr_select_t;
    typedef enum logic {FlagAlu, FlagBus} flag_select_t;
    typedef enum logic [2:0] {BusNone, BusMem, BusPc, BusLr, BusAlu, BusFlags, BusMulHi} bus_select_t;
    typedef enum logic [1:0] {SpHold, SpInc, SpDec, SpLoad} sp_op_t;
    typedef enum logic [1:0] {MulIdle, MulRun, MulDone} mul_state_t;
endpackage

// File: rtl/datapath_p_mul.sv
// mul_seq: unsigned shift-add multiplier, one multiplier bit per cycle.
module mul_seq
    import datapath_p_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_lo,
    output logic [DATA_W-1:0] o_hi
);
    localparam int CW = $clog2(DATA_W);
    mul_state_t        r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_a, r_hi, r_lo;
    logic [DATA_W:0]   w_sum;
    // r_lo starts as the multiplier and is shifted out as product bits shift in
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    assign o_lo  = r_lo;
    assign o_hi  = r_hi;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= MulIdle;
            r_cnt   <= '0;
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                MulIdle: if (i_start) begin
                    r_a     <= i_a;
                    r_lo    <= i_b;
                    r_hi    <= '0;
                    r_cnt   <= '0;
                    r_state <= MulRun;
                    o_busy  <= 1'b1;
                end
                MulRun: begin
                    {r_hi, r_lo} <= {w_sum, r_lo[DATA_W-1:1]};
                    r_cnt        <= r_cnt + CW'(1);
                    if (r_cnt == CW'(DATA_W - 1)) begin
                        r_state <= MulDone;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end
                end
                default: r_state <= MulIdle;
            endcase
        end
    end
endmodule

// File: rtl/datapath_p.sv
// datapath_p: CPU datapath with PC/LR/SP/IR, register file, ALU, flags,
// a single muxed system bus and a sequential multiplier.
module datapath_p
    import datapath_p_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                NREGS      = 8,
    parameter logic [DATA_W-1:0] PC_RESET   = '0,
    parameter logic [DATA_W-1:0] SP_RESET   = '1,
    parameter logic [DATA_W-1:0] INT_VECTOR = 'h10
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_data_in,
    output logic [DATA_W-1:0] o_sys_bus,
    output logic [7:0]        o_opcode,
    output logic [3:0]        o_flags,
    input  alu_functions_t    i_alu_op,
    input  pc_select_t        i_pc_sel,
    input  op1_select_t       i_op1_sel,
    input  op2_select_t       i_op2_sel,
    input  imm_select_t       i_imm_sel,
    input  wd_select_t        i_wd_sel,
    input  rs1_select_t       i_rs1_sel,
    input  rw_select_t        i_rw_sel,
    input  lr_select_t        i_lr_sel,
    input  flag_select_t      i_flag_sel,
    input  bus_select_t       i_bus_sel,
    input  sp_op_t            i_sp_op,
    input  logic              i_pc_we,
    input  logic              i_lr_we,
    input  logic              i_ir_we,
    input  logic              i_reg_we,
    input  logic              i_alu_we,
    input  logic              i_flag_we,
    input  logic              i_mul_start,
    output logic              o_mul_busy,
    output logic              o_mul_done
);
    logic [DATA_W-1:0] r_pc, r_lr, r_sp, r_alu_out, r_mul_hi;
    logic [IR_W-1:0]   r_ir;
    logic [3:0]        r_flags;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [2:0]        w_rs1, w_rs2, w_rw;
    logic [DATA_W-1:0] w_rd1, w_rd2, w_imm, w_op1, w_op2, w_bb, w_alu_res;
    logic [DATA_W-1:0] w_wdata, w_pc1, w_pc_next, w_mul_lo, w_mul_hi;
    logic [DATA_W:0]   w_sum;
    logic              w_sub, w_cin, w_arith;
    logic [3:0]        w_alu_flags;
    assign o_opcode  = r_ir[15:8];
    assign o_flags   = r_flags;
    assign w_rs2     = r_ir[4:2];
    assign w_rs1     = i_rs1_sel == Rs1Rd ? r_ir[10:8] : i_rs1_sel == Rs1Ra ? r_ir[7:5] : 3'd7;
    assign w_rw      = i_rw_sel == RwRd ? r_ir[10:8] : i_rw_sel == RwRa ? r_ir[7:5] : 3'd7;
    assign w_rd1     = int'(w_rs1) < NREGS ? r_regs[w_rs1] : '0;
    assign w_rd2     = int'(w_rs2) < NREGS ? r_regs[w_rs2] : '0;
    assign w_imm     = i_imm_sel == ImmLong ? {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]} : {{(DATA_W-5){r_ir[4]}}, r_ir[4:0]};
    assign w_op1     = i_op1_sel == Op1Pc ? r_pc : i_op1_sel == Op1Sp ? r_sp : w_rd1;
    assign w_op2     = i_op2_sel == Op2Imm ? w_imm : w_rd2;
    assign w_wdata   = i_wd_sel == WdAlu ? w_alu_res : o_sys_bus;
    assign w_pc1     = r_pc + DATA_W'(1);
    assign w_pc_next = i_pc_sel == PcLr ? r_lr : i_pc_sel == PcAlu ? w_alu_res :
                       i_pc_sel == PcSys ? o_sys_bus : i_pc_sel == Pc1 ? w_pc1 : INT_VECTOR;
    always_comb begin
        case (i_bus_sel)
            BusMem:   o_sys_bus = i_data_in;
            BusPc:    o_sys_bus = r_pc;
            BusLr:    o_sys_bus = r_lr;
            BusAlu:   o_sys_bus = r_alu_out;
            BusFlags: o_sys_bus = {{(DATA_W-4){1'b0}}, r_flags};
            BusMulHi: o_sys_bus = r_mul_hi;
            default:  o_sys_bus = '0;
        endcase
    end
    // subtraction is a + ~b + cin, so carry-out is the not-borrow flag
    always_comb begin
        w_sub   = i_alu_op inside {AluSub, AluSbc};
        w_arith = i_alu_op inside {AluAdd, AluAdc, AluSub, AluSbc};
        w_bb    = w_sub ? ~w_op2 : w_op2;
        w_cin   = i_alu_op == AluSub ? 1'b1 : i_alu_op inside {AluAdc, AluSbc} ? r_flags[1] : 1'b0;
        w_sum   = {1'b0, w_op1} + {1'b0, w_bb} + (DATA_W+1)'(w_cin);
        case (i_alu_op)
            AluAnd:   w_alu_res = w_op1 & w_op2;
            AluOr:    w_alu_res = w_op1 | w_op2;
            AluXor:   w_alu_res = w_op1 ^ w_op2;
            AluPassA: w_alu_res = w_op1;
            AluPassB: w_alu_res = w_op2;
            default:  w_alu_res = w_sum[DATA_W-1:0];
        endcase
        w_alu_flags = {w_alu_res[DATA_W-1], w_alu_res == '0, w_arith & w_sum[DATA_W],
                       w_arith & (w_op1[DATA_W-1] == w_bb[DATA_W-1]) & (w_alu_res[DATA_W-1] != w_op1[DATA_W-1])};
    end
    mul_seq #(.DATA_W(DATA_W)) u_mul (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_start (i_mul_start),
        .i_a     (w_op1),
        .i_b     (w_op2),
        .o_busy  (o_mul_busy),
        .o_done  (o_mul_done),
        .o_lo    (w_mul_lo),
        .o_hi    (w_mul_hi)
    );
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc      <= PC_RESET;
            r_sp      <= SP_RESET;
            r_lr      <= '0;
            r_ir      <= '0;
            r_alu_out <= '0;
            r_mul_hi  <= '0;
            r_flags   <= '0;
            for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
        end else begin
            if (i_pc_we) r_pc <= w_pc_next;
            if (i_lr_we) r_lr <= i_lr_sel == LrSys ? o_sys_bus : w_pc1;
            if (i_ir_we) r_ir <= o_sys_bus[IR_W-1:0];
            if (i_reg_we && int'(w_rw) < NREGS) r_regs[w_rw] <= w_wdata;
            if (i_flag_we) r_flags <= i_flag_sel == FlagBus ? o_sys_bus[3:0] : w_alu_flags;
            r_sp <= i_sp_op == SpInc ? r_sp + DATA_W'(1) : i_sp_op == SpDec ? r_sp - DATA_W'(1) :
                    i_sp_op == SpLoad ? w_alu_res : r_sp;
            if (o_mul_done) begin
                r_alu_out <= w_mul_lo;
                r_mul_hi  <= w_mul_hi;
            end else if (i_alu_we) begin
                r_alu_out <= w_alu_res;
            end
        end
    end
endmodule

// File: doc/datapath_p.md
# datapath_p

Parametrised successor datapath for the microcoded CPU, sitting between the control FSM and the memory/system bus. It holds the PC, LR, SP, IR, ALU output, flags and register file, and drives a single muxed system bus instead of tristate drivers. It adds a sequential shift-add multiplier with a start/busy/done handshake and a latched flags register. It supports widths of 16 bits and above.

## Interface
- DATA_W, 16: datapath width. Must be ≥16. Instructions are always 16 bits.
- NREGS, 8: number of general registers, ≤8. Register index fields are 3 bits; indices ≥NREGS read 0 and ignore writes.
- PC_RESET, 0: PC value after reset.
- SP_RESET, all-ones: SP value after reset.
- INT_VECTOR, 'h10: value loaded into PC by PcInt.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- DataIn  in  DATA_W  memory read data.
- SysBus  out  DATA_W  muxed bus value.
- Opcode  out  8  Ir[15:8].
- Flags  out  4  latched {N,Z,C,V}.
- AluOp, PcSel, Op1Sel, Op2Sel, ImmSel, WdSel, Rs1Sel, RwSel, LrSel, FlagSel, BusSel, SpOp  in  enum  control selects.
- PcWe, LrWe, IrWe, RegWe, AluWe, FlagWe  in  1 each  register write enables.
- MulStart  in  1  starts a multiply of Op1×Op2.
- MulBusy  out  1  multiplier running.
- MulDone  out  1  one-cycle pulse when the product is written.

## Operation
- SysBus by BusSel:
  - BusMem → DataIn
  - BusPc → Pc
  - BusLr → Lr
  - BusAlu → AluOut
  - BusFlags → zero-extended Flags
  - BusMulHi → MulHi
  - BusNone → 0
  - Exactly one source at a time, so there is no contention.
- IR loads SysBus[15:0] when IrWe. The upper IR bits do not exist.
- Immediates: ImmShort sign-extends Ir[4:0] to DATA_W; ImmLong sign-extends Ir[7:0].
- Register addressing:
  - Rs2 = Ir[4:2].
  - Rs1: Rs1Rd = Ir[10:8], Rs1Ra = Ir[7:5], otherwise 7.
  - Rw: RwRd = Ir[10:8], RwRa = Ir[7:5], RwSeven = 7.
- Register writes: WData = SysBus (WdSys) or AluRes (WdAlu). A read of the register being written in the same cycle returns the old value.
- Op1 = Rd1, Pc or Sp. Op2 = Rd2 or the extended immediate.
- ALU is combinational at DATA_W; carry-in is Flags.C. Its functions are the existing alu_functions_t set.
  - C is carry-out for add, and not-borrow for sub.
  - V is signed overflow.
  - N = MSB; Z = result==0.
- Flags register loads when FlagWe: ALU flags (FlagAlu) or SysBus[3:0] (FlagBus).
- PC loads when PcWe: Lr, AluRes, SysBus, Pc+1 (wraps modulo 2^DATA_W) or INT_VECTOR.
- LR loads when LrWe: Pc+1 or SysBus.
- SpOp: SpHold; SpInc = Sp+1; SpDec = Sp−1; SpLoad = AluRes. Wraps modulo 2^DATA_W.
- AluOut loads AluRes when AluWe.
- Multiplier: unsigned Op1×Op2, one bit per cycle.
  - The low half goes to AluOut and the high half to MulHi.
  - On its completion cycle the multiplier write overrides AluWe.

## Timing
- Reset:
  - Pc = PC_RESET, Sp = SP_RESET.
  - Lr, Ir, AluOut, MulHi, Flags and all registers = 0.
  - MulBusy = 0, MulDone = 0.
  - Reset wins over every enable.
- All register loads take effect on the edge where the enable is sampled high; the new value is visible the next cycle.
- Multiplier FSM: IDLE → RUN → DONE → IDLE.
  - MulStart sampled in IDLE captures the operands; MulBusy goes high the next cycle.
  - RUN lasts exactly DATA_W cycles.
  - DONE lasts one cycle: MulDone=1, MulBusy=0, and the product is written that edge.
  - Latency from MulStart to the product being readable is DATA_W+2 cycles.
- MulStart while RUN or DONE is ignored and does not queue.
- Operand changes after capture do not affect the result.
- Reset during RUN aborts: no MulDone, no write, and the FSM returns to IDLE.

## Structure
- The opcodes package gains bus_select_t and sp_op_t, and BusMulHi joins bus_select_t. Existing enums are reused unchanged.
- Sub-module mul_seq is parametrised by DATA_W. It contains the FSM, counter, and accumulator/shift registers.
- Register file and ALU are inline, parametrised.

## Test plan
- Reset with PC_RESET='h20 → Pc='h20, Sp='hFFFF, Flags=0, SysBus=0 under BusNone.
- Add R1=0x7FFF + R2=1 with FlagWe → AluOut=0x8000, Flags N=1 Z=0 C=0 V=1.
- MulStart with 0xFFFF×0xFFFF at DATA_W=16:
  - MulBusy high for exactly 16 cycles.
  - MulDone pulse, then AluOut=0x0001 and MulHi=0xFFFE.
  - A second MulStart during RUN is ignored.
- Reset asserted in RUN cycle 5 → MulBusy=0, no MulDone, AluOut stays 0.
- Sp=0 with SpDec → 0xFFFF; SpInc → 0x0000. PcSel=PcInt → Pc=INT_VECTOR.
- DATA_W=32 regression: ImmLong 0x80 → Op2=0xFFFFFF80; Pc=0xFFFFFFFF with Pc1 → 0.
